osd_frame_ctrl: RTL and testbench
=================================

// Module: osd_frame_ctrl
// PURPOSE
//  Frame-synchronous controller for the OSD overlay stage of the LCD pipeline. Runs in the pixel-clock domain.
//  Takes the colour-bar timing vsync and accepts config from a host over a valid/ready handshake.
//  Drives the OSD window position, colours, enable and blink gate. Changes are applied only at frame boundaries
//  (no tearing). Also runs an optional bouncing-window motion and a blink scheduler.
// PARAMETERS
//  H_ACTIVE      480   active pixels per line
//  V_ACTIVE      272   active lines per frame
//  WIN_W         256   OSD window width (px); XMAX = H_ACTIVE-WIN_W
//  WIN_H         32    OSD window height (lines); YMAX = V_ACTIVE-WIN_H
//  FRAME_DIV     2     frames per motion step (>=1)
//  BLINK_FRAMES  30    frames per blink half-period (>=1)
//  VS_POL        0     active level of i_vs (0 = active-low)
// PORTS
//  pclk        in   1   pixel clock (video_pll c0); only clock
//  rst_n       in   1   synchronous reset, active-low
//  i_vs        in   1   vsync from timing generator
//  cfg_valid   in   1   host config valid
//  cfg_ready   out  1   controller can accept config
//  cfg_x       in   12  window left x
//  cfg_y       in   12  window top y
//  cfg_step    in   4   motion step (px per motion frame)
//  cfg_fg      in   24  foreground RGB888
//  cfg_bg      in   24  background RGB888
//  cfg_en      in   1   OSD enable
//  cfg_move    in   1   enable bounce motion
//  cfg_blink   in   1   enable blink
//  frame_start out  1   one-cycle pulse per frame boundary
//  osd_x       out  12  active window x
//  osd_y       out  12  active window y
//  osd_fg      out  24  active foreground colour
//  osd_bg      out  24  active background colour
//  osd_show    out  1   cfg_en & (cfg_blink ? blink_phase : 1)
// BEHAVIOUR
//  Reset (rst_n low at a pclk edge):
//   - osd_x=0, osd_y=0, osd_fg=24'hFFFFFF, osd_bg=0, osd_show=0, frame_start=0, cfg_ready=1.
//   - dir_x=dir_y=0 (increasing); frame and blink counters=0; blink_phase=1; pending=0.
//   - vs_d loads the inactive level. Reset mid-frame discards any pending config.
//  Boundary detect: vs_d is i_vs registered. Boundary = (i_vs==VS_POL) && (vs_d!=VS_POL).
//   - frame_start is registered and asserts on the cycle after the boundary edge.
//   - All osd_* updates are committed on that same edge (latency 1 from the vsync sampled active).
//  Config handshake:
//   - cfg_ready = ~pending.
//   - cfg_valid&cfg_ready captures all cfg_* into the shadow register and sets pending.
//   - cfg_valid while cfg_ready=0 is ignored; the host holds it until ready.
//  At a boundary with pending=1, in priority order:
//   - Load the active set from the shadow; clear pending.
//   - Clamp x to XMAX and y to YMAX if exceeded.
//   - Set dir=0; clear the frame counter; no motion step this frame.
//   - Clear the blink counter; blink_phase=1.
//  Capture in the same cycle as a boundary: the boundary uses the old state (pending=0, so no apply).
//   The new config is held and applied at the next boundary.
//  At a boundary with pending=0, motion (if move=1): frame counter increments.
//   When it reaches FRAME_DIV-1, it wraps to 0 and steps each axis:
//   - dir=0: if pos+step >= MAX then pos=MAX, dir=1; else pos+=step.
//   - dir=1: if pos <= step then pos=0, dir=0; else pos-=step.
//   - Compute in 13 bits (no wrap). step=0 freezes position.
//  Blink: every boundary increments the blink counter.
//   At BLINK_FRAMES-1 it wraps to 0 and toggles blink_phase. It runs regardless of cfg_blink.
//  osd_show is registered and updates only at boundaries. All outputs are stable within a frame.
//  States: IDLE (en=0, outputs held), RUN (en=1). The transition happens only at a boundary via config apply.
// TESTING
//  - Reset: hold rst_n=0 for 3 cycles -> osd_x=0, osd_y=0, osd_fg=FFFFFF, osd_show=0, cfg_ready=1.
//  - Handshake: pulse cfg_valid (x=100, y=50, en=1) -> cfg_ready=0 until the next boundary.
//    A second cfg_valid while not ready is ignored.
//    One cycle after the vs edge: osd_x=100, osd_y=50, osd_show=1, cfg_ready=1.
//  - Bounce: x=220, step=8, move=1, FRAME_DIV=1, XMAX=224 -> next frames x=224 (dir flips), 216, 208.
//    With y=0, the y axis mirrors at YMAX=240.
//  - Blink: BLINK_FRAMES=2, blink=1 -> osd_show pattern 1,1,0,0,1,1 over successive frames.
//  - Simultaneous: cfg_valid&ready in the same cycle as the boundary -> not applied that frame;
//    applied at the following boundary.
//  - Reset mid-frame with a pending config -> after reset, outputs are at reset values and cfg_ready=1.
//    The old config is never applied.

Source files
------------

// File: rtl/osd_frame_ctrl.sv
// osd_frame_ctrl
//   Frame-synchronous OSD overlay controller in the pixel-clock domain. A host writes a
//   configuration into a shadow register over a valid/ready handshake. The shadow is applied to
//   the active set only at the next vsync boundary, so the window never tears. The controller
//   also runs an optional bouncing-window motion and a blink scheduler.
//
// Ports
//   pclk, rst_n          pixel clock; synchronous active-low reset
//   i_vs                 vsync from the timing generator (active level VS_POL)
//   cfg_valid/cfg_ready  host config handshake; cfg_ready is low while a config is pending
//   cfg_x/y/step/fg/bg   window position, motion step and colours to apply
//   cfg_en/move/blink    OSD enable, bounce-motion enable and blink enable
//   frame_start          one-cycle pulse on the cycle after a frame boundary
//   osd_x/y/fg/bg/show   active window state; changes only at frame boundaries
module osd_frame_ctrl #(
  parameter int unsigned H_ACTIVE     = 480,
  parameter int unsigned V_ACTIVE     = 272,
  parameter int unsigned WIN_W        = 256,
  parameter int unsigned WIN_H        = 32,
  parameter int unsigned FRAME_DIV    = 2,
  parameter int unsigned BLINK_FRAMES = 30,
  parameter bit          VS_POL       = 1'b0
) (
  input  logic        pclk,
  input  logic        rst_n,
  input  logic        i_vs,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [11:0] cfg_x,
  input  logic [11:0] cfg_y,
  input  logic [3:0]  cfg_step,
  input  logic [23:0] cfg_fg,
  input  logic [23:0] cfg_bg,
  input  logic        cfg_en,
  input  logic        cfg_move,
  input  logic        cfg_blink,
  output logic        frame_start,
  output logic [11:0] osd_x,
  output logic [11:0] osd_y,
  output logic [23:0] osd_fg,
  output logic [23:0] osd_bg,
  output logic        osd_show
);

  localparam logic [11:0] XMax     = 12'(H_ACTIVE - WIN_W);
  localparam logic [11:0] YMax     = 12'(V_ACTIVE - WIN_H);
  localparam logic [15:0] FcntLast = 16'(FRAME_DIV - 1);
  localparam logic [15:0] BcntLast = 16'(BLINK_FRAMES - 1);

  localparam logic [0:0] StIdle = 1'b0;
  localparam logic [0:0] StRun  = 1'b1;

  // One motion step on one axis; result is {new_dir, new_pos}. Sum kept in 13 bits so it
  // cannot wrap past the limit.
  function automatic logic [12:0] step_axis(input logic [11:0] pos, input logic dir,
                                            input logic [3:0] step, input logic [11:0] lim);
    logic [12:0] sum;
    sum = {1'b0, pos} + {9'd0, step};
    if (!dir) begin
      if (sum >= {1'b0, lim}) return {1'b1, lim};
      else                    return {1'b0, sum[11:0]};
    end else begin
      if (pos <= {8'd0, step}) return {1'b0, 12'd0};
      else                     return {1'b1, pos - {8'd0, step}};
    end
  endfunction

  logic        vs_q, vs_d;
  logic        pend_q, pend_d;
  logic [11:0] sh_x_q, sh_x_d, sh_y_q, sh_y_d;
  logic [3:0]  sh_step_q, sh_step_d;
  logic [23:0] sh_fg_q, sh_fg_d, sh_bg_q, sh_bg_d;
  logic        sh_en_q, sh_en_d, sh_move_q, sh_move_d, sh_blink_q, sh_blink_d;

  logic [0:0]  state_q, state_d;
  logic [11:0] x_q, x_d, y_q, y_d;
  logic [3:0]  step_q, step_d;
  logic [23:0] fg_q, fg_d, bg_q, bg_d;
  logic        move_q, move_d, blink_q, blink_d;
  logic        dx_q, dx_d, dy_q, dy_d;
  logic [15:0] fcnt_q, fcnt_d, bcnt_q, bcnt_d;
  logic        phase_q, phase_d;
  logic        show_q, show_d;
  logic        fs_q, fs_d;
  logic        boundary, capture;

  always_comb begin
    vs_d       = i_vs;
    pend_d     = pend_q;
    sh_x_d     = sh_x_q;
    sh_y_d     = sh_y_q;
    sh_step_d  = sh_step_q;
    sh_fg_d    = sh_fg_q;
    sh_bg_d    = sh_bg_q;
    sh_en_d    = sh_en_q;
    sh_move_d  = sh_move_q;
    sh_blink_d = sh_blink_q;
    state_d    = state_q;
    x_d        = x_q;
    y_d        = y_q;
    step_d     = step_q;
    fg_d       = fg_q;
    bg_d       = bg_q;
    move_d     = move_q;
    blink_d    = blink_q;
    dx_d       = dx_q;
    dy_d       = dy_q;
    fcnt_d     = fcnt_q;
    bcnt_d     = bcnt_q;
    phase_d    = phase_q;
    show_d     = show_q;

    boundary = (i_vs == VS_POL) && (vs_q != VS_POL);
    // Uses the pre-boundary pending flag, so a capture on a boundary waits one more frame.
    capture  = cfg_valid && !pend_q;
    fs_d     = boundary;

    if (boundary) begin
      if (pend_q) begin
        x_d     = (sh_x_q > XMax) ? XMax : sh_x_q;
        y_d     = (sh_y_q > YMax) ? YMax : sh_y_q;
        step_d  = sh_step_q;
        fg_d    = sh_fg_q;
        bg_d    = sh_bg_q;
        move_d  = sh_move_q;
        blink_d = sh_blink_q;
        state_d = sh_en_q ? StRun : StIdle;
        dx_d    = 1'b0;
        dy_d    = 1'b0;
        fcnt_d  = '0;
        bcnt_d  = '0;
        phase_d = 1'b1;
        show_d  = sh_en_q;
        pend_d  = 1'b0;
      end else begin
        if (bcnt_q == BcntLast) begin
          bcnt_d  = '0;
          phase_d = ~phase_q;
        end else begin
          bcnt_d = bcnt_q + 16'd1;
        end
        // Motion is frozen while idle so the outputs hold.
        if (state_q == StRun && move_q) begin
          if (fcnt_q == FcntLast) begin
            fcnt_d      = '0;
            {dx_d, x_d} = step_axis(x_q, dx_q, step_q, XMax);
            {dy_d, y_d} = step_axis(y_q, dy_q, step_q, YMax);
          end else begin
            fcnt_d = fcnt_q + 16'd1;
          end
        end
        show_d = (state_q == StRun) && (blink_q ? phase_d : 1'b1);
      end
    end

    if (capture) begin
      sh_x_d     = cfg_x;
      sh_y_d     = cfg_y;
      sh_step_d  = cfg_step;
      sh_fg_d    = cfg_fg;
      sh_bg_d    = cfg_bg;
      sh_en_d    = cfg_en;
      sh_move_d  = cfg_move;
      sh_blink_d = cfg_blink;
      pend_d     = 1'b1;
    end
  end

  always_ff @(posedge pclk) begin
    if (!rst_n) begin
      vs_q       <= ~VS_POL;
      pend_q     <= 1'b0;
      sh_x_q     <= '0;
      sh_y_q     <= '0;
      sh_step_q  <= '0;
      sh_fg_q    <= '0;
      sh_bg_q    <= '0;
      sh_en_q    <= 1'b0;
      sh_move_q  <= 1'b0;
      sh_blink_q <= 1'b0;
      state_q    <= StIdle;
      x_q        <= '0;
      y_q        <= '0;
      step_q     <= '0;
      fg_q       <= 24'hFFFFFF;
      bg_q       <= '0;
      move_q     <= 1'b0;
      blink_q    <= 1'b0;
      dx_q       <= 1'b0;
      dy_q       <= 1'b0;
      fcnt_q     <= '0;
      bcnt_q     <= '0;
      phase_q    <= 1'b1;
      show_q     <= 1'b0;
      fs_q       <= 1'b0;
    end else begin
      vs_q       <= vs_d;
      pend_q     <= pend_d;
      sh_x_q     <= sh_x_d;
      sh_y_q     <= sh_y_d;
      sh_step_q  <= sh_step_d;
      sh_fg_q    <= sh_fg_d;
      sh_bg_q    <= sh_bg_d;
      sh_en_q    <= sh_en_d;
      sh_move_q  <= sh_move_d;
      sh_blink_q <= sh_blink_d;
      state_q    <= state_d;
      x_q        <= x_d;
      y_q        <= y_d;
      step_q     <= step_d;
      fg_q       <= fg_d;
      bg_q       <= bg_d;
      move_q     <= move_d;
      blink_q    <= blink_d;
      dx_q       <= dx_d;
      dy_q       <= dy_d;
      fcnt_q     <= fcnt_d;
      bcnt_q     <= bcnt_d;
      phase_q    <= phase_d;
      show_q     <= show_d;
      fs_q       <= fs_d;
    end
  end

  assign cfg_ready   = ~pend_q;
  assign frame_start = fs_q;
  assign osd_x       = x_q;
  assign osd_y       = y_q;
  assign osd_fg      = fg_q;
  assign osd_bg      = bg_q;
  assign osd_show    = show_q;

endmodule

// File: tb/tb_osd_frame_ctrl.sv
// Self-checking bench for osd_frame_ctrl: directed scenarios plus randomized frames, every
// output compared each cycle against a frame-level reference model.
module tb_osd_frame_ctrl;

  localparam int FD   = 2;
  localparam int BF   = 3;
  localparam int XMAX = 480 - 256;
  localparam int YMAX = 272 - 32;

  logic        pclk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_vs = 1'b1;
  logic        cfg_valid = 1'b0;
  logic        cfg_ready;
  logic [11:0] cfg_x = '0, cfg_y = '0;
  logic [3:0]  cfg_step = '0;
  logic [23:0] cfg_fg = '0, cfg_bg = '0;
  logic        cfg_en = 1'b0, cfg_move = 1'b0, cfg_blink = 1'b0;
  logic        frame_start;
  logic [11:0] osd_x, osd_y;
  logic [23:0] osd_fg, osd_bg;
  logic        osd_show;

  always #5 pclk = ~pclk;

  osd_frame_ctrl #(
    .H_ACTIVE(480), .V_ACTIVE(272), .WIN_W(256), .WIN_H(32),
    .FRAME_DIV(FD), .BLINK_FRAMES(BF), .VS_POL(1'b0)
  ) dut (
    .pclk(pclk), .rst_n(rst_n), .i_vs(i_vs), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_x(cfg_x), .cfg_y(cfg_y), .cfg_step(cfg_step), .cfg_fg(cfg_fg), .cfg_bg(cfg_bg),
    .cfg_en(cfg_en), .cfg_move(cfg_move), .cfg_blink(cfg_blink), .frame_start(frame_start),
    .osd_x(osd_x), .osd_y(osd_y), .osd_fg(osd_fg), .osd_bg(osd_bg), .osd_show(osd_show)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
  endtask

  // Reference model: frame-level state kept as plain integers.
  int  m_vs_prev, m_pend, m_fs;
  int  s_x, s_y, s_step, s_fg, s_bg, s_en, s_move, s_blink;
  int  a_x, a_y, a_step, a_fg, a_bg, a_en, a_move, a_blink;
  int  a_dx, a_dy;  // +1 moving towards the limit, -1 moving back to 0
  int  m_frames, m_bframes, m_phase, m_show;

  function automatic void move_axis(inout int pos, inout int dir, input int step, input int lim);
    if (dir > 0) begin
      if (pos + step >= lim) begin pos = lim; dir = -1; end
      else pos = pos + step;
    end else begin
      if (pos <= step) begin pos = 0; dir = 1; end
      else pos = pos - step;
    end
  endfunction

  task automatic model_edge();
    bit bnd, cap;
    if (!rst_n) begin
      m_vs_prev = 1; m_pend = 0; m_fs = 0;
      a_x = 0; a_y = 0; a_fg = 'hFFFFFF; a_bg = 0; a_en = 0; a_move = 0; a_blink = 0;
      a_step = 0; a_dx = 1; a_dy = 1; m_frames = 0; m_bframes = 0; m_phase = 1; m_show = 0;
      return;
    end
    bnd = (i_vs == 1'b0) && (m_vs_prev != 0);
    cap = cfg_valid && (m_pend == 0);
    if (bnd) begin
      if (m_pend != 0) begin
        a_x = (s_x > XMAX) ? XMAX : s_x;
        a_y = (s_y > YMAX) ? YMAX : s_y;
        a_step = s_step; a_fg = s_fg; a_bg = s_bg;
        a_en = s_en; a_move = s_move; a_blink = s_blink;
        a_dx = 1; a_dy = 1; m_frames = 0; m_bframes = 0; m_phase = 1;
        m_pend = 0;
      end else begin
        m_bframes++;
        if (m_bframes == BF) begin m_bframes = 0; m_phase = 1 - m_phase; end
        if (a_en != 0 && a_move != 0) begin
          m_frames++;
          if (m_frames == FD) begin
            m_frames = 0;
            move_axis(a_x, a_dx, a_step, XMAX);
            move_axis(a_y, a_dy, a_step, YMAX);
          end
        end
      end
      m_show = (a_en != 0 && (a_blink == 0 || m_phase != 0)) ? 1 : 0;
    end
    m_fs = bnd ? 1 : 0;
    if (cap) begin
      s_x = int'(cfg_x); s_y = int'(cfg_y); s_step = int'(cfg_step);
      s_fg = int'(cfg_fg); s_bg = int'(cfg_bg);
      s_en = int'(cfg_en); s_move = int'(cfg_move); s_blink = int'(cfg_blink);
      m_pend = 1;
    end
    m_vs_prev = int'(i_vs);
  endtask

  task automatic compare_all();
    check("osd_x", 32'(osd_x), 32'(a_x));
    check("osd_y", 32'(osd_y), 32'(a_y));
    check("osd_fg", 32'(osd_fg), 32'(a_fg));
    check("osd_bg", 32'(osd_bg), 32'(a_bg));
    check("osd_show", 32'(osd_show), 32'(m_show));
    check("frame_start", 32'(frame_start), 32'(m_fs));
    check("cfg_ready", 32'(cfg_ready), 32'(1 - m_pend));
  endtask

  task automatic tick();
    @(posedge pclk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic set_cfg(input int x, input int y, input int step, input bit en,
                         input bit mv, input bit bl);
    cfg_x = 12'(x); cfg_y = 12'(y); cfg_step = 4'(step);
    cfg_fg = 24'($urandom); cfg_bg = 24'($urandom);
    cfg_en = en; cfg_move = mv; cfg_blink = bl;
  endtask

  task automatic pulse_cfg();
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  // One frame: vsync active (low) for two cycles, then len-2 active cycles.
  task automatic run_frame(input int len, input bit rnd);
    for (int i = 0; i < len; i++) begin
      i_vs = (i < 2) ? 1'b0 : 1'b1;
      if (rnd) begin
        set_cfg($urandom_range(0, 300), $urandom_range(0, 300), $urandom_range(0, 15),
                $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)));
        cfg_valid = ($urandom_range(0, 9) == 0);
      end
      tick();
    end
    cfg_valid = 1'b0;
  endtask

  initial begin
    // Reset
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_x", 32'(osd_x), 32'd0);
    check("rst_fg", 32'(osd_fg), 32'hFFFFFF);
    check("rst_show", 32'(osd_show), 32'd0);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    rst_n = 1'b1;
    repeat (4) tick();

    // Handshake; the second request while busy must be ignored
    set_cfg(100, 50, 0, 1'b1, 1'b0, 1'b0);
    pulse_cfg();
    check("hs_busy", 32'(cfg_ready), 32'd0);
    set_cfg(7, 9, 0, 1'b0, 1'b0, 1'b0);
    pulse_cfg();
    repeat (3) tick();
    i_vs = 1'b0;
    tick();
    check("hs_x", 32'(osd_x), 32'd100);
    check("hs_y", 32'(osd_y), 32'd50);
    check("hs_show", 32'(osd_show), 32'd1);
    check("hs_ready", 32'(cfg_ready), 32'd1);
    tick();
    i_vs = 1'b1;
    repeat (6) tick();

    // Bounce near XMAX, y bouncing from 0
    set_cfg(220, 0, 8, 1'b1, 1'b1, 1'b0);
    pulse_cfg();
    for (int f = 0; f < 10; f++) run_frame(8, 1'b0);

    // Blink
    set_cfg(10, 10, 0, 1'b1, 1'b0, 1'b1);
    pulse_cfg();
    for (int f = 0; f < 10; f++) run_frame(8, 1'b0);

    // Capture on the boundary cycle itself: held until the following boundary
    set_cfg(33, 44, 1, 1'b1, 1'b1, 1'b0);
    i_vs = 1'b0;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
    check("sim_not_applied", 32'(osd_x), 32'd10);
    tick();
    i_vs = 1'b1;
    repeat (6) tick();
    run_frame(8, 1'b0);
    check("sim_applied", 32'(osd_x), 32'd33);

    // Reset mid-frame with a pending config: it must never be applied
    set_cfg(200, 200, 3, 1'b1, 1'b1, 1'b1);
    pulse_cfg();
    rst_n = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    check("mid_rst_ready", 32'(cfg_ready), 32'd1);
    for (int f = 0; f < 3; f++) run_frame(8, 1'b0);
    check("mid_rst_x", 32'(osd_x), 32'd0);

    // Randomized frames with occasional resets
    for (int f = 0; f < 200; f++) begin
      if ($urandom_range(0, 39) == 0) begin
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
      end
      run_frame($urandom_range(4, 14), 1'b1);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
